// File: rtl/wb_commit_arbiter.sv
// wb_commit_arbiter
//   Write-back stage. Each functional-unit channel completes out of order into
//   its own small FIFO. At most one buffered result per cycle is committed to
//   the RF/HI/LO write ports. A round-robin pointer selects which channel commits.
//   All wb_* outputs are registered, so a result pushed at edge E0 is visible
//   on wb_* after E1 at the earliest.
// Ports
//   clk, rst_n        clock (rising edge), async active-low reset
//   flush             drop every buffered result and clear the enables
//   ch_valid/ready    per-channel push handshake (ready = FIFO not full)
//   ch_*              per-channel result fields, channel k at [k*W +: W]
//   wb_*              registered commit outputs
//   wb_grant_ch       channel that produced the current wb_* contents
//   wb_pending        any FIFO non-empty
module wb_commit_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [NUM_CH-1:0]          ch_valid,
    output logic [NUM_CH-1:0]          ch_ready,
    input  logic [NUM_CH-1:0]          ch_rf_wena,
    input  logic [NUM_CH-1:0]          ch_hi_wena,
    input  logic [NUM_CH-1:0]          ch_lo_wena,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_waddr,
    input  logic [NUM_CH*DATA_W-1:0]   ch_rf_wdata,
    input  logic [NUM_CH*DATA_W-1:0]   ch_hi_wdata,
    input  logic [NUM_CH*DATA_W-1:0]   ch_lo_wdata,
    output logic                       wb_rf_wena,
    output logic [ADDR_W-1:0]          wb_rf_waddr,
    output logic [DATA_W-1:0]          wb_rf_wdata,
    output logic                       wb_hi_wena,
    output logic [DATA_W-1:0]          wb_hi_wdata,
    output logic                       wb_lo_wena,
    output logic [DATA_W-1:0]          wb_lo_wdata,
    output logic [$clog2(NUM_CH)-1:0]  wb_grant_ch,
    output logic                       wb_pending
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic              rf_wena;
        logic              hi_wena;
        logic              lo_wena;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] rf_wdata;
        logic [DATA_W-1:0] hi_wdata;
        logic [DATA_W-1:0] lo_wdata;
    } entry_t;

    function automatic logic [CH_W-1:0] ch_inc(input logic [CH_W-1:0] v);
        return (v == CH_W'(NUM_CH - 1)) ? '0 : v + CH_W'(1);
    endfunction

    entry_t            head [NUM_CH];
    logic [NUM_CH-1:0] not_empty;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;

    logic              grant_vld;
    logic [CH_W-1:0]   grant_idx;
    logic [CH_W-1:0]   scan;
    logic [CH_W-1:0]   rr_q, rr_d;

    // ---------------- per-channel FIFOs ----------------
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        entry_t           mem_q [FIFO_DEPTH];
        entry_t           mem_d [FIFO_DEPTH];
        logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
        logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        entry_t           in_entry;

        assign in_entry = {ch_rf_wena[k], ch_hi_wena[k], ch_lo_wena[k],
                           ch_waddr[k*ADDR_W +: ADDR_W],
                           ch_rf_wdata[k*DATA_W +: DATA_W],
                           ch_hi_wdata[k*DATA_W +: DATA_W],
                           ch_lo_wdata[k*DATA_W +: DATA_W]};

        // Ready looks only at the registered count: a full FIFO stays
        // not-ready even when it is being popped this cycle.
        assign full[k]      = (cnt_q == CNT_W'(FIFO_DEPTH));
        assign not_empty[k] = (cnt_q != '0);
        assign ch_ready[k]  = ~full[k];
        assign push[k]      = ch_valid[k] & ~full[k] & ~flush;
        assign pop[k]       = grant_vld & (grant_idx == CH_W'(k)) & ~flush;
        assign head[k]      = mem_q[rd_ptr_q];

        always_comb begin
            mem_d    = mem_q;
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            cnt_d    = cnt_q;
            if (flush) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                cnt_d    = '0;
            end else begin
                if (push[k]) begin
                    mem_d[wr_ptr_q] = in_entry;
                    wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
                end
                if (pop[k]) begin
                    rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
                end
                if (push[k] && !pop[k]) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (!push[k] && pop[k]) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                cnt_q    <= cnt_d;
            end
        end

        // Payload storage needs no reset; the count guards every read.
        always_ff @(posedge clk) begin
            mem_q <= mem_d;
        end
    end

    assign wb_pending = |not_empty;

    // ---------------- round-robin pick ----------------
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan      = rr_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!grant_vld && not_empty[scan]) begin
                grant_vld = 1'b1;
                grant_idx = scan;
            end
            scan = ch_inc(scan);
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (flush) begin
            rr_d = '0;
        end else if (grant_vld) begin
            rr_d = ch_inc(grant_idx);
        end
    end

    // ---------------- registered commit port ----------------
    logic              wb_rf_wena_q, wb_rf_wena_d;
    logic [ADDR_W-1:0] wb_rf_waddr_q, wb_rf_waddr_d;
    logic [DATA_W-1:0] wb_rf_wdata_q, wb_rf_wdata_d;
    logic              wb_hi_wena_q, wb_hi_wena_d;
    logic [DATA_W-1:0] wb_hi_wdata_q, wb_hi_wdata_d;
    logic              wb_lo_wena_q, wb_lo_wena_d;
    logic [DATA_W-1:0] wb_lo_wdata_q, wb_lo_wdata_d;
    logic [CH_W-1:0]   wb_grant_ch_q, wb_grant_ch_d;

    always_comb begin
        wb_rf_wena_d  = 1'b0;
        wb_hi_wena_d  = 1'b0;
        wb_lo_wena_d  = 1'b0;
        wb_rf_waddr_d = wb_rf_waddr_q;
        wb_rf_wdata_d = wb_rf_wdata_q;
        wb_hi_wdata_d = wb_hi_wdata_q;
        wb_lo_wdata_d = wb_lo_wdata_q;
        wb_grant_ch_d = wb_grant_ch_q;
        if (!flush && grant_vld) begin
            // r0 is hardwired zero: suppress the RF write, keep HI/LO.
            wb_rf_wena_d  = head[grant_idx].rf_wena && (head[grant_idx].waddr != '0);
            wb_hi_wena_d  = head[grant_idx].hi_wena;
            wb_lo_wena_d  = head[grant_idx].lo_wena;
            wb_rf_waddr_d = head[grant_idx].waddr;
            wb_rf_wdata_d = head[grant_idx].rf_wdata;
            wb_hi_wdata_d = head[grant_idx].hi_wdata;
            wb_lo_wdata_d = head[grant_idx].lo_wdata;
            wb_grant_ch_d = grant_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q          <= '0;
            wb_rf_wena_q  <= 1'b0;
            wb_rf_waddr_q <= '0;
            wb_rf_wdata_q <= '0;
            wb_hi_wena_q  <= 1'b0;
            wb_hi_wdata_q <= '0;
            wb_lo_wena_q  <= 1'b0;
            wb_lo_wdata_q <= '0;
            wb_grant_ch_q <= '0;
        end else begin
            rr_q          <= rr_d;
            wb_rf_wena_q  <= wb_rf_wena_d;
            wb_rf_waddr_q <= wb_rf_waddr_d;
            wb_rf_wdata_q <= wb_rf_wdata_d;
            wb_hi_wena_q  <= wb_hi_wena_d;
            wb_hi_wdata_q <= wb_hi_wdata_d;
            wb_lo_wena_q  <= wb_lo_wena_d;
            wb_lo_wdata_q <= wb_lo_wdata_d;
            wb_grant_ch_q <= wb_grant_ch_d;
        end
    end

    assign wb_rf_wena  = wb_rf_wena_q;
    assign wb_rf_waddr = wb_rf_waddr_q;
    assign wb_rf_wdata = wb_rf_wdata_q;
    assign wb_hi_wena  = wb_hi_wena_q;
    assign wb_hi_wdata = wb_hi_wdata_q;
    assign wb_lo_wena  = wb_lo_wena_q;
    assign wb_lo_wdata = wb_lo_wdata_q;
    assign wb_grant_ch = wb_grant_ch_q;

endmodule
